local_inject_unit: RTL and testbench

- Traffic-source endpoint on the router's local port. It is the transmit counterpart of the local ejection/logging unit.
- After a start pulse, it generates PacketCount packets addressed from node (X,Y,Z) and drives each onto inject_local with a one-cycle inject_receive_local strobe.
- Each strobe is gated by the router's InjectSlotAvail_local credit signal.
- It provides programmable startup delay, inter-packet gap, and a done flag for bench/system sequencing.

---
 rtl/local_inject_if.sv | 33 +++
 rtl/local_inject_unit.sv | 116 +++++++++++
 tb/tb_local_inject_unit.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/local_inject_if.sv
// Local-port injection bus between the traffic source and the router's local input.
// The master side is the injecting endpoint; the slave side is the router/bench.
interface local_inject_if #(
    parameter int DataWidth = 256
) ();
    logic                 start;
    logic                 InjectSlotAvail_local;
    logic [DataWidth-1:0] inject_local;
    logic                 inject_receive_local;
    logic                 busy;
    logic                 done;
    logic [15:0]          sent_count;

    modport master (
        input  start,
        input  InjectSlotAvail_local,
        output inject_local,
        output inject_receive_local,
        output busy,
        output done,
        output sent_count
    );

    modport slave (
        output start,
        output InjectSlotAvail_local,
        input  inject_local,
        input  inject_receive_local,
        input  busy,
        input  done,
        input  sent_count
    );
endinterface

// File: rtl/local_inject_unit.sv
// Traffic source on the router local port: after start, injects PacketCount packets
// from node (X,Y,Z), each gated by the router's local slot-available credit.
module local_inject_unit #(
    parameter logic [3:0]             X           = 4'd0,
    parameter logic [3:0]             Y           = 4'd0,
    parameter logic [3:0]             Z           = 4'd0,
    parameter int                     PacketCount = 256,
    parameter int                     DataWidth   = 256,
    parameter logic [31:0]            PcktType    = 32'd0,
    parameter int                     IndexPos    = 128,
    parameter int                     IndexWidth  = 16,
    parameter int                     WeightPos   = 144,
    parameter int                     WeightWidth = 8,
    parameter logic [WeightWidth-1:0] LogWeight   = '0,
    parameter int                     StartDelay  = 0,
    parameter int                     InjectGap   = 0
) (
    input  logic           clk,
    input  logic           rst,
    local_inject_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_SEND,
        S_GAP,
        S_LAST,
        S_DONE
    } state_t;

    localparam logic [15:0] LastSeq   = 16'(PacketCount - 1);
    localparam logic [31:0] DelayLoad = 32'(StartDelay - 1);
    localparam logic [31:0] GapLoad   = 32'(InjectGap - 1);

    state_t      state;
    logic [31:0] wait_cnt;

    function automatic logic [DataWidth-1:0] build_packet(input logic [15:0] seq);
        logic [DataWidth-1:0] pkt;
        pkt                           = '0;
        pkt[DataWidth-1]              = 1'b1;
        pkt[WeightPos +: WeightWidth] = LogWeight;
        pkt[IndexPos +: IndexWidth]   = IndexWidth'(seq);
        pkt[127:96]                   = PcktType;
        pkt[95:64]                    = {28'b0, Z};
        pkt[63:32]                    = {28'b0, Y};
        pkt[31:0]                     = {28'b0, X};
        return pkt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= S_IDLE;
            wait_cnt                 <= '0;
            bus.inject_local         <= '0;
            bus.inject_receive_local <= 1'b0;
            bus.busy                 <= 1'b0;
            bus.done                 <= 1'b0;
            bus.sent_count           <= '0;
        end else begin
            bus.inject_receive_local <= 1'b0;
            bus.inject_local         <= '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        bus.sent_count <= '0;
                        bus.done       <= 1'b0;
                        bus.busy       <= 1'b1;
                        if (StartDelay > 0) begin
                            state    <= S_DELAY;
                            wait_cnt <= DelayLoad;
                        end else begin
                            state <= S_SEND;
                        end
                    end
                end

                S_DELAY, S_GAP: begin
                    if (wait_cnt == '0) begin
                        state <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt - 32'd1;
                    end
                end

                S_SEND: begin
                    if (bus.InjectSlotAvail_local) begin
                        bus.inject_receive_local <= 1'b1;
                        bus.inject_local         <= build_packet(bus.sent_count);
                        bus.sent_count           <= bus.sent_count + 16'd1;
                        if (bus.sent_count == LastSeq) begin
                            state <= S_LAST;
                        end else if (InjectGap > 0) begin
                            state    <= S_GAP;
                            wait_cnt <= GapLoad;
                        end
                    end
                end

                // Final strobe cycle: busy stays high so done never overlaps the last strobe.
                S_LAST: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= S_DONE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_local_inject_unit.sv
// Scoreboard bench: three differently parameterised injectors driven by directed and
// random stimulus, checked against an edge-based reference model.
module tb_local_inject_unit;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        rst_v   = '1;
    logic [NI-1:0]        start_v = '0;
    logic [NI-1:0]        avail_v = '0;
    logic [NI-1:0]        strobe_v;
    logic [NI-1:0]        busy_v;
    logic [NI-1:0]        done_v;
    logic [NI-1:0][255:0] pkt_v;
    logic [NI-1:0][15:0]  cnt_v;

    int checks = 0;
    int errors = 0;
    int unsigned edge_n = 0;
    int unsigned nstrobe [NI];

    function automatic int pc_of(input int i);
        case (i) 0: return 4; 1: return 3; default: return 8; endcase
    endfunction
    function automatic int dly_of(input int i);
        case (i) 0: return 0; 1: return 5; default: return 0; endcase
    endfunction
    function automatic int gap_of(input int i);
        case (i) 0: return 0; 1: return 2; default: return 0; endcase
    endfunction
    function automatic int x_of(input int i);
        case (i) 0: return 0; 1: return 1; default: return 7; endcase
    endfunction
    function automatic int y_of(input int i);
        case (i) 0: return 0; 1: return 2; default: return 9; endcase
    endfunction
    function automatic int z_of(input int i);
        case (i) 0: return 0; 1: return 3; default: return 15; endcase
    endfunction
    function automatic int lw_of(input int i);
        case (i) 0: return 0; 1: return 'h5A; default: return 'hC3; endcase
    endfunction
    function automatic logic [31:0] ty_of(input int i);
        case (i) 0: return 32'h0; 1: return 32'hCAFE_0001; default: return 32'h0000_0042; endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : u
        local_inject_if #(.DataWidth(256)) bus ();
        assign bus.start                 = start_v[g];
        assign bus.InjectSlotAvail_local = avail_v[g];
        assign strobe_v[g]               = bus.inject_receive_local;
        assign busy_v[g]                 = bus.busy;
        assign done_v[g]                 = bus.done;
        assign pkt_v[g]                  = bus.inject_local;
        assign cnt_v[g]                  = bus.sent_count;

        local_inject_unit #(
            .X          (4'(x_of(g))),
            .Y          (4'(y_of(g))),
            .Z          (4'(z_of(g))),
            .PacketCount(pc_of(g)),
            .DataWidth  (256),
            .PcktType   (ty_of(g)),
            .IndexPos   (128),
            .IndexWidth (16),
            .WeightPos  (144),
            .WeightWidth(8),
            .LogWeight  (8'(lw_of(g))),
            .StartDelay (dly_of(g)),
            .InjectGap  (gap_of(g))
        ) dut (
            .clk(clk),
            .rst(rst_v[g]),
            .bus(bus)
        );
    end

    // Expected packet straight from the field layout.
    function automatic logic [255:0] exp_pkt(input int i, input int unsigned n);
        logic [255:0] p;
        p          = '0;
        p[255]     = 1'b1;
        p[151:144] = 8'(lw_of(i));
        p[143:128] = 16'(n);
        p[127:96]  = ty_of(i);
        p[95:64]   = 32'(z_of(i));
        p[63:32]   = 32'(y_of(i));
        p[31:0]    = 32'(x_of(i));
        return p;
    endfunction

    typedef struct {
        logic [255:0] pkt;
        int unsigned  edge_k;
    } exp_t;

    exp_t exp_q [NI][$];

    // Reference model state, in terms of clock edges.
    bit          m_busy [NI];
    bit          m_done [NI];
    bit          m_pend [NI];
    int unsigned m_cnt  [NI];
    int unsigned m_idx  [NI];
    int unsigned m_elig [NI];
    int unsigned m_fin  [NI];

    always @(posedge clk) edge_n++;

    task automatic model_step(input int i);
        bit   b_prev;
        exp_t e;
        b_prev = m_busy[i];
        if (rst_v[i]) begin
            m_busy[i] = 0; m_done[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
            exp_q[i].delete();
        end else if (!b_prev && start_v[i]) begin
            m_busy[i] = 1; m_done[i] = 0; m_pend[i] = 0; m_cnt[i] = 0; m_idx[i] = 0;
            m_elig[i] = edge_n + 1 + dly_of(i);
        end else if (b_prev) begin
            if (m_pend[i]) begin
                if (edge_n == m_fin[i]) begin
                    m_busy[i] = 0; m_done[i] = 1; m_pend[i] = 0;
                end
            end else if (edge_n >= m_elig[i] && avail_v[i]) begin
                e.pkt    = exp_pkt(i, m_idx[i]);
                e.edge_k = edge_n;
                exp_q[i].push_back(e);
                m_idx[i]++;
                m_cnt[i] = m_idx[i];
                if (m_idx[i] == pc_of(i)) begin
                    m_pend[i] = 1;
                    m_fin[i]  = edge_n + 1;
                end else begin
                    m_elig[i] = edge_n + 1 + gap_of(i);
                end
            end
        end
        checks++;
        if (busy_v[i] !== m_busy[i] || done_v[i] !== m_done[i] || cnt_v[i] !== 16'(m_cnt[i])) begin
            errors++;
            $display("FAIL status[%0d] edge %0d: busy=%b done=%b cnt=%0d, required busy=%0d done=%0d cnt=%0d",
                     i, edge_n, busy_v[i], done_v[i], cnt_v[i], m_busy[i], m_done[i], m_cnt[i]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) model_step(i);
    end

    // Monitor: pops expected packets whenever a strobe is presented.
    always @(posedge clk) begin
        exp_t e;
        #2;
        for (int i = 0; i < NI; i++) begin
            if (strobe_v[i] === 1'b1) begin
                nstrobe[i]++;
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL strobe[%0d] edge %0d: unexpected strobe pkt=%h, required no strobe", i, edge_n, pkt_v[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    if (pkt_v[i] !== e.pkt || edge_n != e.edge_k) begin
                        errors++;
                        $display("FAIL packet[%0d] edge %0d: got %h, required %h at edge %0d",
                                 i, edge_n, pkt_v[i], e.pkt, e.edge_k);
                    end
                end
            end else begin
                checks++;
                if (strobe_v[i] !== 1'b0 || pkt_v[i] !== '0) begin
                    errors++;
                    $display("FAIL idlebus[%0d] edge %0d: strobe=%b pkt=%h, required 0 and all-zero", i, edge_n, strobe_v[i], pkt_v[i]);
                end
                if (exp_q[i].size() > 0 && exp_q[i][0].edge_k <= edge_n) begin
                    e = exp_q[i].pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing[%0d] edge %0d: no strobe, required packet %h", i, edge_n, e.pkt);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk); start_v[i] = 1'b1;
        @(negedge clk); start_v[i] = 1'b0;
    endtask

    task automatic pulse_rst(input int i, input int n);
        @(negedge clk); rst_v[i] = 1'b1;
        cycles(n);
        rst_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (!(done_v[i] === 1'b1 && busy_v[i] === 1'b0) && n < budget) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_done[%0d]: done=%b busy=%b after %0d cycles, required done=1 busy=0", i, done_v[i], busy_v[i], n);
        end
    endtask

    task automatic wait_strobes(input int i, input int unsigned target, input int budget);
        int n = 0;
        while (nstrobe[i] < target && n < budget) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_strobes[%0d]: %0d strobes, required %0d", i, nstrobe[i], target);
        end
    endtask

    task automatic expect_count(input int i, input logic [15:0] want);
        checks++;
        if (cnt_v[i] !== want) begin
            errors++;
            $display("FAIL sent_count[%0d]: got %0d, required %0d", i, cnt_v[i], want);
        end
    endtask

    task automatic rand_phase(input int i, input int n);
        int k = 0;
        repeat (n) begin
            @(negedge clk);
            avail_v[i] = ($urandom_range(0, 3) != 0);
            start_v[i] = ($urandom_range(0, 19) == 0);
            rst_v[i]   = ($urandom_range(0, 249) == 0);
        end
        @(negedge clk);
        start_v[i] = 1'b0; rst_v[i] = 1'b0; avail_v[i] = 1'b1;
        while (busy_v[i] === 1'b1 && k < 200) begin
            @(negedge clk); k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL drain[%0d]: busy=%b after 200 cycles, required 0", i, busy_v[i]);
        end
    endtask

    task automatic seq0();
        pulse_rst(0, 3);
        avail_v[0] = 1'b1;
        cycles(20);
        pulse_start(0);
        wait_done(0, 50);
        expect_count(0, 16'd4);
        pulse_start(0);
        wait_strobes(0, nstrobe[0] + 2, 50);
        pulse_start(0);
        wait_done(0, 50);
        expect_count(0, 16'd4);
        pulse_start(0);
        wait_done(0, 50);
        rand_phase(0, 600);
    endtask

    task automatic seq1();
        pulse_rst(1, 3);
        avail_v[1] = 1'b1;
        pulse_start(1);
        wait_done(1, 80);
        expect_count(1, 16'd3);
        pulse_start(1);
        wait_strobes(1, nstrobe[1] + 1, 50);
        avail_v[1] = 1'b0;
        cycles(5);
        avail_v[1] = 1'b1;
        wait_done(1, 80);
        expect_count(1, 16'd3);
        rand_phase(1, 600);
    endtask

    task automatic seq2();
        pulse_rst(2, 3);
        avail_v[2] = 1'b1;
        pulse_start(2);
        wait_strobes(2, nstrobe[2] + 2, 50);
        pulse_rst(2, 1);
        cycles(2);
        pulse_start(2);
        wait_done(2, 80);
        expect_count(2, 16'd8);
        rand_phase(2, 600);
    endtask

    initial begin
        fork
            seq0();
            seq1();
            seq2();
        join
        cycles(3);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL leftover[%0d]: %0d expected packets never seen, required 0", i, exp_q[i].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
